// File: rtl/sqrt2_unit_arbiter.sv
// sqrt2_unit_arbiter: round-robin issue of operand pairs to one shared add/sub-div-sqrt2 unit
// Ports: clk/rst (async active-low); req, in_1_bus, in_2_bus from requesters;
// gnt one-hot combinational grant; unit_in_1/2 registered operands to the unit;
// unit_add/unit_sub unit results; res_valid/res_id/add_out/sub_out tagged results;
// busy = any operation in flight; op_cnt = issued operation count (wraps).
module sqrt2_unit_arbiter #(
  parameter int N = 4,
  parameter int NREQ = 4,
  parameter int LAT = 3,
  localparam int W = 2**N,
  localparam int IW = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] in_1_bus,
  input  logic [NREQ*W-1:0] in_2_bus,
  output logic [NREQ-1:0]   gnt,
  output logic [W-1:0]      unit_in_1,
  output logic [W-1:0]      unit_in_2,
  input  logic [W-1:0]      unit_add,
  input  logic [W-1:0]      unit_sub,
  output logic              res_valid,
  output logic [IW-1:0]     res_id,
  output logic [W-1:0]      add_out,
  output logic [W-1:0]      sub_out,
  output logic              busy,
  output logic [15:0]       op_cnt
);
  logic [IW-1:0] last_q, last_d, win;
  logic found;
  logic [W-1:0] u1_q, u1_d, u2_q, u2_d;
  logic [15:0] cnt_q, cnt_d;
  logic [LAT:0] tv_q, tv_d;
  logic [LAT:0][IW-1:0] tid_q, tid_d;
  // search starts one past the last winner and wraps modulo NREQ
  always_comb begin
    found = 1'b0;
    win = '0;
    for (int i = 1; i <= NREQ; i++)
      if (!found && req[(int'(last_q) + i) % NREQ]) begin
        found = 1'b1;
        win = IW'((int'(last_q) + i) % NREQ);
      end
    gnt = found ? NREQ'(1) << win : '0;
  end
  // tags shift every cycle with no stall so they stay aligned with the unit latency
  always_comb begin
    last_d = found ? win : last_q;
    u1_d = found ? in_1_bus[int'(win)*W +: W] : u1_q;
    u2_d = found ? in_2_bus[int'(win)*W +: W] : u2_q;
    cnt_d = cnt_q + {15'd0, found};
    tv_d = {tv_q[LAT-1:0], found};
    tid_d = {tid_q[LAT-1:0], found ? win : IW'(0)};
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_q <= IW'(NREQ - 1);
      u1_q <= '0;
      u2_q <= '0;
      cnt_q <= '0;
      tv_q <= '0;
      tid_q <= '0;
    end else begin
      last_q <= last_d;
      u1_q <= u1_d;
      u2_q <= u2_d;
      cnt_q <= cnt_d;
      tv_q <= tv_d;
      tid_q <= tid_d;
    end
  end
  assign unit_in_1 = u1_q;
  assign unit_in_2 = u2_q;
  assign res_valid = tv_q[LAT];
  assign res_id = tv_q[LAT] ? tid_q[LAT] : '0;
  assign add_out = unit_add;
  assign sub_out = unit_sub;
  assign busy = |tv_q;
  assign op_cnt = cnt_q;
endmodule

// File: doc/sqrt2_unit_arbiter.md
# sqrt2_unit_arbiter

Round-robin scheduler that shares one add/subtract-then-divide-by-√2 butterfly unit among up to NREQ requesters in the 8-point FFT datapath. It accepts at most one operand pair per cycle and drives the shared unit's operand inputs from registers. It tracks each issued operation's requester ID through a tag pipeline matched to the unit latency. It returns the unit's sum and difference results tagged with the originating requester.

## Interface
Parameters:
- N, 4, data width is 2**N bits (W).
- NREQ, 4, number of requesters (2..8).
- LAT, 3, clock edges from the shared unit's operand inputs to its valid outputs.

Ports (IW = clog2(NREQ)):
- clk  in  1  single clock; all state on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- req  in  NREQ  per-requester request; held with operands until granted.
- in_1_bus  in  NREQ*W  requester k's first operand at bits [k*W +: W].
- in_2_bus  in  NREQ*W  requester k's second operand, same packing.
- gnt  out  NREQ  one-hot, combinational; operands of the granted requester are taken at this edge.
- unit_in_1  out  W  registered operand 1 to the shared unit.
- unit_in_2  out  W  registered operand 2 to the shared unit.
- unit_add  in  W  (in_1+in_2)/√2 from the shared unit.
- unit_sub  in  W  (in_1−in_2)/√2 from the shared unit.
- res_valid  out  1  result of an issued operation is present this cycle.
- res_id  out  IW  requester that owns the current result.
- add_out  out  W  equals unit_add, pass-through.
- sub_out  out  W  equals unit_sub, pass-through.
- busy  out  1  at least one operation is in flight.
- op_cnt  out  16  count of issued operations; wraps at 2^16.

## Operation
- Arbitration:
  - Round-robin pointer `last` holds the index of the most recent winner.
  - The search order is last+1, last+2, … modulo NREQ.
  - The first set req bit wins, and gnt is one-hot for that requester.
  - gnt is all zero when req is all zero.
- Issue (edge at the end of a cycle with a grant):
  - The winner's operands are loaded into unit_in_1 and unit_in_2.
  - `last` is updated to the winner.
  - op_cnt increments.
  - The tag {valid=1, id=winner} enters stage 0 of the tag pipeline.
- No grant:
  - unit_in_1 and unit_in_2 hold their previous values.
  - `last` is unchanged.
  - A tag with valid=0 enters stage 0.
- Tag pipeline:
  - LAT+1 stages, shifted every cycle with no stall.
  - The final stage drives res_valid and res_id.
  - res_id is 0 whenever res_valid is 0.
- busy is the OR of all tag-stage valid bits.
- No result back-pressure: the consumer samples add_out and sub_out on every cycle where res_valid is high.
- Requester protocol:
  - A requester whose gnt is high in a cycle may present new operands, or drop req, in the next cycle.
  - A requester that keeps req high is re-arbitrated every cycle and is not guaranteed consecutive grants while others request.
- No arithmetic is performed in this block. Widths pass through unchanged.

## Timing
- Reset (rst=0, takes effect asynchronously):
  - unit_in_1 = unit_in_2 = 0.
  - All tags are invalid, so res_valid = 0, res_id = 0 and busy = 0.
  - op_cnt = 0.
  - last = NREQ−1, so requester 0 has first priority.
  - gnt stays purely combinational from req and last.
- Latency: a grant in cycle t gives unit_in valid in cycle t+1 and res_valid/res_id in cycle t+1+LAT (cycle t+4 at default).
- Throughput: one operation per cycle, sustained.
- Fairness: with all NREQ requests held high, grants rotate 0,1,…,NREQ−1,0,… with no requester skipped.
- Simultaneous events: only the single winner is granted. All other requests stay pending with no loss.
- Reset mid-operation:
  - All in-flight tags are discarded, and no res_valid is raised for them after reset release.
  - Arbitration restarts from requester 0.
- Single requester: a continuously held req is granted every cycle.
- op_cnt wrap: 16'hFFFF increments to 16'h0000.

## Test plan
- Single op:
  - Stimulus: req=4'b0100, in_1=16'h0100, in_2=16'h0040 at cycle 0.
  - Response: gnt=4'b0100 in cycle 0; unit_in_1=16'h0100 and unit_in_2=16'h0040 in cycle 1; res_valid=1 with res_id=2 in cycle 4 only; op_cnt=1.
- All four requesting, held for 8 cycles:
  - Response: gnt sequence 0,1,2,3,0,1,2,3.
  - Results return in cycles 4..11 with the same id order.
  - busy stays high from cycle 1 through cycle 11.
- Pointer resume:
  - Stimulus: grant requester 1, then go idle 3 cycles, then req=4'b0011.
  - Response: requester 0 is granted first, because the search starts at 2 and wraps.
- Back-to-back single requester:
  - Stimulus: req[3] held for 5 cycles with a new operand each cycle.
  - Response: 5 consecutive grants; 5 consecutive res_valid with id=3, operand order preserved (checked against a bench model of the unit).
- Reset in flight:
  - Stimulus: assert rst=0 in cycle 2 after grants in cycles 0 and 1, and release it in cycle 3.
  - Response: res_valid stays 0 through cycle 10; op_cnt=0; the next grant goes to the lowest requesting index.
- Counter wrap:
  - Stimulus: preload op_cnt to 16'hFFFE via 65534 issued operations, then issue 2 more.
  - Response: op_cnt = 16'h0000.
